// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the shift-instruction control unit: FSM state
// encoding, supported opcodes, IR field positions and an opcode check.
package cpu_ctrl_pkg;

  localparam int unsigned IR_W      = 32;
  localparam int unsigned OPC_W     = 5;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned STATE_W   = 4;

  // IR field bit positions
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned RC_LSB  = 15;

  // Supported shift/rotate opcodes
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01001;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 4'd0,
    T0    = 4'd1,
    T1    = 4'd2,
    T2    = 4'd3,
    T3    = 4'd4,
    T4    = 4'd5,
    T5    = 4'd6,
    FAULT = 4'd7
  } state_e;

  // True for the opcodes this unit knows how to sequence
  function automatic logic is_shift_op(input logic [OPC_W-1:0] op);
    logic ok;
    case (op)
      OP_SHL, OP_SHR, OP_SHRA, OP_ROR, OP_ROL: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// One-hot general-register select decoder.
// Ports:
//   idx_i  register index
//   en_i   enable; all outputs low when clear
//   sel_o  one-hot select, all-zero for indices at or above NUM_REGS
module reg_select_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [REG_IDX_W-1:0] idx_i,
  input  logic                 en_i,
  output logic [NUM_REGS-1:0]  sel_o
);

  // Out-of-range indices simply match no output bit
  always_comb begin
    sel_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (en_i && (32'(idx_i) == i)) begin
        sel_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_control_unit.sv
// Hardwired control FSM sequencing the shift datapath through
// fetch (T0-T2) and a register/register shift or rotate (T3-T5).
// Ports:
//   Clock, Clear         clock; synchronous active-high reset
//   run, stop            level controls from the top level
//   mem_ready            memory read data valid
//   ir                   IR contents fed back from the datapath
//   PCout/Zlowout/MDRout bus-drive selects
//   MARin/PCin/MDRin/IRin/Yin/ZLowIn  register load enables
//   IncPC, Read          ALU increment request, memory read strobe
//   op_code              ALU operation select
//   r_in, r_out          one-hot general-register load / drive
//   instr_done           pulse in T5 of each completed instruction
//   illegal_op           pulse in T3 on an unsupported opcode
//   mem_fault            high while parked in FAULT after a read timeout
//   state_dbg            current state encoding
module shift_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned MEM_WAIT_MAX = 8
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                run,
  input  logic                stop,
  input  logic                mem_ready,
  input  logic [IR_W-1:0]     ir,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowIn,
  output logic                IncPC,
  output logic                Read,
  output logic [OPC_W-1:0]    op_code,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                mem_fault,
  output logic [STATE_W-1:0]  state_dbg
);

  localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  // Counter value at which one more idle T1 cycle exhausts the wait budget
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic [OPC_W-1:0]     opc;
  logic [REG_IDX_W-1:0] ra, rb, rc;
  logic                 opc_legal;

  logic                 r_in_en;
  logic                 r_out_en;
  logic [REG_IDX_W-1:0] r_out_idx;

  assign opc       = ir[OPC_MSB:OPC_LSB];
  assign ra        = ir[RA_MSB:RA_LSB];
  assign rb        = ir[RB_MSB:RB_LSB];
  assign rc        = ir[RC_MSB:RC_LSB];
  assign opc_legal = is_shift_op(opc);
  assign state_dbg = state_q;

  // Low IR bits carry no meaning for shift instructions
  logic unused_ir_low;
  assign unused_ir_low = ^ir[RC_LSB-1:0];

  // State and wait-counter registers
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    ZLowIn     = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    op_code    = 5'b00000;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    mem_fault  = 1'b0;
    r_in_en    = 1'b0;
    r_out_en   = 1'b0;
    r_out_idx  = rb;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = T0;
      end
      T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        ZLowIn  = 1'b1;
        wait_d  = '0;
        state_d = T1;
      end
      T1: begin
        // Re-driving Z onto PC while stalled is harmless: Z is not reloaded
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) begin
          state_d = T2;
        end else if (wait_q == WAIT_LAST) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = T3;
      end
      T3: begin
        if (opc_legal) begin
          r_out_en = 1'b1;
          Yin      = 1'b1;
          state_d  = T4;
        end else begin
          illegal_op = 1'b1;
          state_d    = run ? T0 : IDLE;
        end
      end
      T4: begin
        r_out_en  = 1'b1;
        r_out_idx = rc;
        op_code   = opc;
        ZLowIn    = 1'b1;
        state_d   = T5;
      end
      T5: begin
        Zlowout    = 1'b1;
        // R0 is not a legal shift destination
        r_in_en    = (ra != '0);
        instr_done = 1'b1;
        state_d    = (run && !stop) ? T0 : IDLE;
      end
      FAULT: begin
        mem_fault = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_r_in_dec (
    .idx_i (ra),
    .en_i  (r_in_en),
    .sel_o (r_in)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_r_out_dec (
    .idx_i (r_out_idx),
    .en_i  (r_out_en),
    .sel_o (r_out)
  );

endmodule

// File: tb/tb_shift_control_unit.sv
// Directed bench for shift_control_unit: per-cycle comparison of the
// full output set against hand-built expected vectors.
module tb_shift_control_unit;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_T0    = 4'd1;
  localparam logic [3:0] ST_T1    = 4'd2;
  localparam logic [3:0] ST_T2    = 4'd3;
  localparam logic [3:0] ST_T3    = 4'd4;
  localparam logic [3:0] ST_T4    = 4'd5;
  localparam logic [3:0] ST_T5    = 4'd6;
  localparam logic [3:0] ST_FAULT = 4'd7;

  // Strobe order: PCout Zlowout MDRout MARin PCin MDRin IRin Yin ZLowIn IncPC Read
  localparam logic [10:0] SB_NONE = 11'b000_0000_0000;
  localparam logic [10:0] SB_T0   = 11'b100_1000_0110;
  localparam logic [10:0] SB_T1   = 11'b010_0110_0001;
  localparam logic [10:0] SB_T2   = 11'b001_0001_0000;
  localparam logic [10:0] SB_T3   = 11'b000_0000_1000;
  localparam logic [10:0] SB_T4   = 11'b000_0000_0100;
  localparam logic [10:0] SB_T5   = 11'b010_0000_0000;
  localparam logic [15:0] Z16     = 16'h0000;

  logic        Clock;
  logic        Clear, run, stop, mem_ready;
  logic [31:0] ir;
  logic        PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZLowIn, IncPC, Read;
  logic [4:0]  op_code;
  logic [15:0] r_in, r_out;
  logic        instr_done, illegal_op, mem_fault;
  logic [3:0]  state_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;

  shift_control_unit #(.NUM_REGS(16), .MEM_WAIT_MAX(8)) dut (
    .Clock(Clock), .Clear(Clear), .run(run), .stop(stop), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .IncPC(IncPC), .Read(Read),
    .op_code(op_code), .r_in(r_in), .r_out(r_out), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_fault(mem_fault), .state_dbg(state_dbg)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Observation vector: state, strobes, op_code, r_out, r_in, {done, illegal, fault}
  logic [54:0] obs;
  assign obs = {state_dbg, PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZLowIn,
                IncPC, Read, op_code, r_out, r_in, instr_done, illegal_op, mem_fault};

  function automatic logic [54:0] mk(input logic [3:0] st, input logic [10:0] sb,
                                     input logic [4:0] op, input logic [15:0] ro,
                                     input logic [15:0] ri, input logic [2:0] fl);
    return {st, sb, op, ro, ri, fl};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic test_reset();
    logic [54:0] idle_v;
    idle_v = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    Clear = 1'b1; run = 1'b1; stop = 1'b0; mem_ready = 1'b1; ir = 32'h38918000;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_cnt++;
      if (obs !== idle_v) begin
        err_cnt++;
        $display("FAIL reset cyc%0d obs=%h exp=%h", i, obs, idle_v);
      end
    end
    Clear = 1'b0; run = 1'b0;
    tick();
    vec_cnt++;
    if (obs !== idle_v) begin
      err_cnt++;
      $display("FAIL reset_hold obs=%h exp=%h", obs, idle_v);
    end
  endtask

  // SHRA R1,R2,R3 then ROL R15,R14,R0 back to back; run dropped mid-way
  task automatic test_basic();
    logic [54:0] exp [0:12];
    exp[0]  = mk(ST_T0, SB_T0, 5'd0, Z16, Z16, 3'b000);
    exp[1]  = mk(ST_T1, SB_T1, 5'd0, Z16, Z16, 3'b000);
    exp[2]  = mk(ST_T2, SB_T2, 5'd0, Z16, Z16, 3'b000);
    exp[3]  = mk(ST_T3, SB_T3, 5'd0, 16'h0004, Z16, 3'b000);
    exp[4]  = mk(ST_T4, SB_T4, 5'b00111, 16'h0008, Z16, 3'b000);
    exp[5]  = mk(ST_T5, SB_T5, 5'd0, Z16, 16'h0002, 3'b100);
    exp[6]  = mk(ST_T0, SB_T0, 5'd0, Z16, Z16, 3'b000);
    exp[7]  = mk(ST_T1, SB_T1, 5'd0, Z16, Z16, 3'b000);
    exp[8]  = mk(ST_T2, SB_T2, 5'd0, Z16, Z16, 3'b000);
    exp[9]  = mk(ST_T3, SB_T3, 5'd0, 16'h4000, Z16, 3'b000);
    exp[10] = mk(ST_T4, SB_T4, 5'b01001, 16'h0001, Z16, 3'b000);
    exp[11] = mk(ST_T5, SB_T5, 5'd0, Z16, 16'h8000, 3'b100);
    exp[12] = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    ir = 32'h38918000; run = 1'b1; stop = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      vec_cnt++;
      if (obs !== exp[i]) begin
        err_cnt++;
        $display("FAIL basic cyc%0d obs=%h exp=%h", i, obs, exp[i]);
      end
      if (i == 6) begin
        ir  = 32'h4FF00000;  // ROL Ra=15 Rb=14 Rc=0
        run = 1'b0;
      end
    end
  endtask

  // Three stalled T1 cycles then data: four cycles of Read
  task automatic test_mem_wait();
    logic [54:0] exp [0:9];
    exp[0] = mk(ST_T0, SB_T0, 5'd0, Z16, Z16, 3'b000);
    for (int j = 1; j <= 4; j++) exp[j] = mk(ST_T1, SB_T1, 5'd0, Z16, Z16, 3'b000);
    exp[5] = mk(ST_T2, SB_T2, 5'd0, Z16, Z16, 3'b000);
    exp[6] = mk(ST_T3, SB_T3, 5'd0, 16'h0004, Z16, 3'b000);
    exp[7] = mk(ST_T4, SB_T4, 5'b00111, 16'h0008, Z16, 3'b000);
    exp[8] = mk(ST_T5, SB_T5, 5'd0, Z16, 16'h0002, 3'b100);
    exp[9] = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    ir = 32'h38918000; run = 1'b1; stop = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vec_cnt++;
      if (obs !== exp[i]) begin
        err_cnt++;
        $display("FAIL mem_wait cyc%0d obs=%h exp=%h", i, obs, exp[i]);
      end
      if (i == 0) run = 1'b0;
      if (i == 4) mem_ready = 1'b1;
    end
  endtask

  // Two instructions each waiting seven cycles and succeeding on the eighth
  task automatic test_back_to_back();
    logic [54:0] exp [0:26];
    logic        rdy [0:26];
    for (int k = 0; k < 2; k++) begin
      exp[k*13] = mk(ST_T0, SB_T0, 5'd0, Z16, Z16, 3'b000);
      rdy[k*13] = 1'b0;
      for (int j = 1; j <= 8; j++) begin
        exp[k*13+j] = mk(ST_T1, SB_T1, 5'd0, Z16, Z16, 3'b000);
        rdy[k*13+j] = (j == 8);
      end
      exp[k*13+9]  = mk(ST_T2, SB_T2, 5'd0, Z16, Z16, 3'b000);
      exp[k*13+10] = mk(ST_T3, SB_T3, 5'd0, 16'h0004, Z16, 3'b000);
      exp[k*13+11] = mk(ST_T4, SB_T4, 5'b00111, 16'h0008, Z16, 3'b000);
      exp[k*13+12] = mk(ST_T5, SB_T5, 5'd0, Z16, 16'h0002, 3'b100);
      for (int j = 9; j <= 12; j++) rdy[k*13+j] = 1'b0;
    end
    exp[26] = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    rdy[26] = 1'b0;
    ir = 32'h38918000; run = 1'b1; stop = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 27; i++) begin
      tick();
      vec_cnt++;
      if (obs !== exp[i]) begin
        err_cnt++;
        $display("FAIL wait_boundary cyc%0d obs=%h exp=%h", i, obs, exp[i]);
      end
      mem_ready = rdy[i];
      if (i == 13) run = 1'b0;
    end
  endtask

  // Eight stalled T1 cycles -> FAULT, sticky until Clear
  task automatic test_mem_fault();
    logic [54:0] exp [0:12];
    exp[0] = mk(ST_T0, SB_T0, 5'd0, Z16, Z16, 3'b000);
    for (int j = 1; j <= 8; j++) exp[j] = mk(ST_T1, SB_T1, 5'd0, Z16, Z16, 3'b000);
    exp[9]  = mk(ST_FAULT, SB_NONE, 5'd0, Z16, Z16, 3'b001);
    exp[10] = mk(ST_FAULT, SB_NONE, 5'd0, Z16, Z16, 3'b001);
    exp[11] = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    exp[12] = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    ir = 32'h38918000; run = 1'b1; stop = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      vec_cnt++;
      if (obs !== exp[i]) begin
        err_cnt++;
        $display("FAIL mem_fault cyc%0d obs=%h exp=%h", i, obs, exp[i]);
      end
      if (i == 9)  mem_ready = 1'b1;
      if (i == 10) Clear = 1'b1;
      if (i == 11) begin Clear = 1'b0; run = 1'b0; end
    end
  endtask

  // Opcode 5'b11111: illegal pulse, restart with run=1, IDLE with run=0
  task automatic test_illegal();
    logic [54:0] exp [0:8];
    for (int k = 0; k < 2; k++) begin
      exp[k*4]   = mk(ST_T0, SB_T0, 5'd0, Z16, Z16, 3'b000);
      exp[k*4+1] = mk(ST_T1, SB_T1, 5'd0, Z16, Z16, 3'b000);
      exp[k*4+2] = mk(ST_T2, SB_T2, 5'd0, Z16, Z16, 3'b000);
      exp[k*4+3] = mk(ST_T3, SB_NONE, 5'd0, Z16, Z16, 3'b010);
    end
    exp[8] = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    ir = 32'hF8000000; run = 1'b1; stop = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      vec_cnt++;
      if (obs !== exp[i]) begin
        err_cnt++;
        $display("FAIL illegal cyc%0d obs=%h exp=%h", i, obs, exp[i]);
      end
      if (i == 4) run = 1'b0;
    end
  endtask

  // SHL with Ra=0: no register write, instr_done still pulses
  task automatic test_ra_zero();
    logic [54:0] exp [0:6];
    exp[0] = mk(ST_T0, SB_T0, 5'd0, Z16, Z16, 3'b000);
    exp[1] = mk(ST_T1, SB_T1, 5'd0, Z16, Z16, 3'b000);
    exp[2] = mk(ST_T2, SB_T2, 5'd0, Z16, Z16, 3'b000);
    exp[3] = mk(ST_T3, SB_T3, 5'd0, 16'h0004, Z16, 3'b000);
    exp[4] = mk(ST_T4, SB_T4, 5'b00101, 16'h0008, Z16, 3'b000);
    exp[5] = mk(ST_T5, SB_T5, 5'd0, Z16, Z16, 3'b100);
    exp[6] = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    ir = 32'h28118000; run = 1'b1; stop = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      vec_cnt++;
      if (obs !== exp[i]) begin
        err_cnt++;
        $display("FAIL ra_zero cyc%0d obs=%h exp=%h", i, obs, exp[i]);
      end
      if (i == 0) run = 1'b0;
    end
  endtask

  // stop raised in T4 with run still high: IDLE after T5
  task automatic test_stop();
    logic [54:0] exp [0:7];
    exp[0] = mk(ST_T0, SB_T0, 5'd0, Z16, Z16, 3'b000);
    exp[1] = mk(ST_T1, SB_T1, 5'd0, Z16, Z16, 3'b000);
    exp[2] = mk(ST_T2, SB_T2, 5'd0, Z16, Z16, 3'b000);
    exp[3] = mk(ST_T3, SB_T3, 5'd0, 16'h0004, Z16, 3'b000);
    exp[4] = mk(ST_T4, SB_T4, 5'b00111, 16'h0008, Z16, 3'b000);
    exp[5] = mk(ST_T5, SB_T5, 5'd0, Z16, 16'h0002, 3'b100);
    exp[6] = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    exp[7] = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    ir = 32'h38918000; run = 1'b1; stop = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vec_cnt++;
      if (obs !== exp[i]) begin
        err_cnt++;
        $display("FAIL stop cyc%0d obs=%h exp=%h", i, obs, exp[i]);
      end
      if (i == 4) stop = 1'b1;
      if (i == 6) begin run = 1'b0; stop = 1'b0; end
    end
  endtask

  // Clear in T4 overrides the instruction and run
  task automatic test_clear_mid();
    logic [54:0] exp [0:6];
    exp[0] = mk(ST_T0, SB_T0, 5'd0, Z16, Z16, 3'b000);
    exp[1] = mk(ST_T1, SB_T1, 5'd0, Z16, Z16, 3'b000);
    exp[2] = mk(ST_T2, SB_T2, 5'd0, Z16, Z16, 3'b000);
    exp[3] = mk(ST_T3, SB_T3, 5'd0, 16'h0004, Z16, 3'b000);
    exp[4] = mk(ST_T4, SB_T4, 5'b00111, 16'h0008, Z16, 3'b000);
    exp[5] = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    exp[6] = mk(ST_IDLE, SB_NONE, 5'd0, Z16, Z16, 3'b000);
    ir = 32'h38918000; run = 1'b1; stop = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      vec_cnt++;
      if (obs !== exp[i]) begin
        err_cnt++;
        $display("FAIL clear_mid cyc%0d obs=%h exp=%h", i, obs, exp[i]);
      end
      if (i == 4) Clear = 1'b1;
      if (i == 5) begin Clear = 1'b0; run = 1'b0; end
    end
  endtask

  initial begin
    Clear = 1'b1; run = 1'b0; stop = 1'b0; mem_ready = 1'b0; ir = 32'h0;
    test_reset();
    test_basic();
    test_mem_wait();
    test_back_to_back();
    test_mem_fault();
    test_illegal();
    test_ra_zero();
    test_stop();
    test_clear_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_control_unit.md
Name: shift_control_unit

Overview:
- Hardwired control-unit FSM that sequences the shift datapath through the instruction cycle: fetch, then a register/register shift or rotate.
- Replaces hand-driven testbench control strobes with the T0–T5 sequence. Operands and destination are decoded from the IR value that the datapath feeds back.
- Sits between the top-level run/stop controls and the datapath's bus-select, register-enable and op_code inputs.
- Adds a memory-ready wait with timeout, illegal-opcode detection, and a per-instruction completion pulse.

Parameters:
- NUM_REGS, 16, number of general registers; width of the one-hot r_in/r_out vectors.
- MEM_WAIT_MAX, 8, maximum T1 cycles spent waiting for mem_ready before a fault.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Clear  in  1  synchronous, active-high reset.
- run  in  1  level; while high, the FSM leaves IDLE and keeps fetching.
- stop  in  1  level; sampled in T5, forces a return to IDLE after the current instruction.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- ir  in  32  datapath IR contents. Fields: opcode[31:27], Ra[26:23] (dest), Rb[22:19] (value), Rc[18:15] (shift count).
- PCout, Zlowout, MDRout  out  1 each  bus-drive selects.
- MARin, PCin, MDRin, IRin, Yin, ZLowIn  out  1 each  register load enables.
- IncPC, Read  out  1 each  ALU increment request; memory read strobe.
- op_code  out  5  ALU operation select.
- r_in  out  NUM_REGS  one-hot general-register load enable.
- r_out  out  NUM_REGS  one-hot general-register bus drive.
- instr_done  out  1  one-cycle pulse on a completed instruction.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- mem_fault  out  1  sticky; set on memory timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset:
  - Clear on a rising edge puts the FSM in IDLE, zeroes the wait counter and clears mem_fault.
  - All outputs are 0 while in IDLE.
  - Clear overrides everything, including mid-instruction and FAULT.
- Output timing:
  - Outputs are a Moore decode of the state register, plus the ir fields in T3–T5. There is no added latency.
  - Each control strobe is high for exactly the cycles the FSM is in its state.
  - Default for every output in every state is 0; op_code defaults to 5'b00000.
- State transitions:
  - IDLE -> T0 when run=1.
  - T0: PCout, MARin, IncPC, ZLowIn. Next state T1; the wait counter is cleared.
  - T1: Zlowout, PCin, Read, MDRin.
    - Stays in T1 while mem_ready=0, incrementing the wait counter. Holding is idempotent because Z is not reloaded.
    - Goes to T2 on mem_ready=1.
    - If the counter reaches MEM_WAIT_MAX with mem_ready still 0, goes to FAULT.
    - mem_ready=1 in the same cycle the counter reaches MEM_WAIT_MAX means success: go to T2.
  - T2: MDRout, IRin. Next state T3. The IR is valid from T3 on.
  - T3: opcode check.
    - Supported opcodes: SHL 5'b00101, SHR 5'b00110, SHRA 5'b00111, ROR 5'b01000, ROL 5'b01001.
    - Supported: r_out[Rb], Yin; next state T4.
    - Unsupported: no strobes, illegal_op pulses, next state T0 if run=1 else IDLE.
  - T4: r_out[Rc], op_code = ir[31:27], ZLowIn. Next state T5.
  - T5: Zlowout, r_in[Ra], instr_done pulse. Next state T0 if run=1 and stop=0, else IDLE.
  - FAULT: mem_fault=1, all strobes 0. Left only via Clear.
- Register index rules:
  - Ra=0 suppresses r_in entirely; R0 is not writable by shifts.
  - Rb/Rc indices at or above NUM_REGS produce all-zero r_out and are otherwise treated as legal.
- run and stop:
  - Deasserting run mid-instruction does not abort; the instruction completes.
  - stop and run are ignored outside IDLE and T5/T3 exits.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enum: IDLE, T0–T5, FAULT;
  - opcode constants: SHL/SHR/SHRA/ROR/ROL;
  - IR field bit positions.
- One natural sub-module, reg_select_decoder: a 4-bit index plus enable in, a one-hot NUM_REGS vector out. It is instantiated for r_in and r_out.

Test Plan:
- Clear=1 for 2 cycles, then run=1, mem_ready=1, ir=32'h38918000 (SHRA, Ra=1, Rb=2, Rc=3). Expect:
  - T0–T5 in 6 cycles;
  - r_out=16'h0004 in T3 and 16'h0008 in T4;
  - op_code=5'b00111 in T4;
  - r_in=16'h0002 in T5;
  - a single instr_done pulse.
- mem_ready held 0 for 3 cycles of T1 -> Read/MDRin high for 4 cycles, T2 entered on the 4th; the same instruction then completes normally.
- mem_ready held 0 for 8 cycles -> FAULT, mem_fault=1 and all strobes 0. A later Clear returns to IDLE with mem_fault=0.
- ir=32'hF8000000 (opcode 5'b11111) -> illegal_op pulse in T3 with no Yin/r_out, then T0 next cycle (run=1).
- ir=32'h28118000 (Ra=0) -> T5 asserts Zlowout but r_in=0; instr_done still pulses.
- stop=1 during T4 of the first instruction -> IDLE after T5 with no new T0. Separately, Clear asserted during T4 -> IDLE next cycle with all outputs 0.
